// File: rtl/cnn_result_writer.sv
// rtl/cnn_result_writer.sv - buffers result words and writes them out as sequential ICB write commands
module cnn_result_writer #(
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [31:0]      res_data,
    output logic             nice_icb_cmd_valid,
    input  logic             nice_icb_cmd_ready,
    output logic [31:0]      nice_icb_cmd_addr,
    output logic             nice_icb_cmd_read,
    output logic [31:0]      nice_icb_cmd_wdata,
    output logic [3:0]       nice_icb_cmd_wmask,
    input  logic             nice_icb_rsp_valid,
    output logic             nice_icb_rsp_ready,
    input  logic             nice_icb_rsp_err,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [31:0]      addr_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] accepted_cnt;
    logic [LEN_W-1:0] issued_cnt;
    logic [OW-1:0]    outstanding;
    logic [OW-1:0]    outstanding_next;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [31:0]      mem [FIFO_DEPTH];
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             rsp_counted;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign res_ready          = (state == RUN) && !full && (accepted_cnt < len_r);
    assign nice_icb_cmd_valid = (state == RUN) && !empty && (outstanding < MAX_OS);
    assign nice_icb_cmd_addr  = addr_r;
    assign nice_icb_cmd_wdata = mem[rd_ptr[AW-1:0]];
    assign nice_icb_cmd_read  = 1'b0;
    assign nice_icb_cmd_wmask = 4'hF;
    assign nice_icb_rsp_ready = 1'b1;

    assign push        = res_valid && res_ready;
    assign pop         = nice_icb_cmd_valid && nice_icb_cmd_ready;
    // A response with nothing in flight is not counted; it only flags an error.
    assign rsp_counted = nice_icb_rsp_valid && (outstanding != '0);

    always_comb begin
        outstanding_next = outstanding;
        if (pop && !rsp_counted) begin
            outstanding_next = outstanding + OW'(1);
        end else if (!pop && rsp_counted) begin
            outstanding_next = outstanding - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= res_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr_r       <= '0;
            len_r        <= '0;
            accepted_cnt <= '0;
            issued_cnt   <= '0;
            outstanding  <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done        <= 1'b0;
            outstanding <= outstanding_next;
            if (push) begin
                wr_ptr       <= wr_ptr + (AW+1)'(1);
                accepted_cnt <= accepted_cnt + LEN_W'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + (AW+1)'(1);
                addr_r     <= addr_r + 32'd4;
                issued_cnt <= issued_cnt + LEN_W'(1);
            end
            if (nice_icb_rsp_valid && (nice_icb_rsp_err || outstanding == '0)) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_r       <= base_addr;
                        len_r        <= len;
                        accepted_cnt <= '0;
                        issued_cnt   <= '0;
                        err          <= 1'b0;
                        busy         <= 1'b1;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (pop && (issued_cnt + LEN_W'(1)) == len_r) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding_next == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
